// File: rtl/sub_bytes_serial.sv
// rtl/sub_bytes_serial.sv - iterative AES SubBytes stage with configurable S-box count
//
// sbox:
//   address   [7:0] byte to substitute
//   sbox_data [7:0] AES forward S-box of address
//
// sub_bytes_serial:
//   BYTES_PER_CYCLE     S-box instances / bytes substituted per clock (1, 2, 4, 8, 16)
//   clk                 single clock, rising edge
//   reset               asynchronous, active-high
//   in_valid/in_ready   input state handshake (in_ready high only while idle)
//   sub_bytes_in        [0:127] input state, byte i at bits [8*i +: 8]
//   out_valid/out_ready output state handshake
//   sub_bytes_out       [0:127] substituted state, valid while out_valid
//   busy                substitution in progress or result waiting

module sbox (
  input  logic [7:0] address,
  output logic [7:0] sbox_data
);

  // Row r holds S(16*r) .. S(16*r+15); entry 0 sits in the most significant byte.
  localparam logic [0:2047] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign sbox_data = SBOX_TABLE[{address, 3'b000} +: 8];

endmodule

module sub_bytes_serial #(
  parameter int BYTES_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] sub_bytes_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] sub_bytes_out,
  output logic         busy
);

  localparam int N  = 16 / BYTES_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [0:127]    st, st_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;

  logic [3:0]      bidx   [BYTES_PER_CYCLE];
  logic [7:0]      sb_in  [BYTES_PER_CYCLE];
  logic [7:0]      sb_out [BYTES_PER_CYCLE];

  // Lane j works on byte cnt*BPC + j; the state register is substituted in place.
  for (genvar j = 0; j < BYTES_PER_CYCLE; j++) begin : g_lane
    assign bidx[j]  = 4'(int'(cnt) * BYTES_PER_CYCLE + j);
    assign sb_in[j] = st[{bidx[j], 3'b000} +: 8];

    sbox u_sbox (
      .address   (sb_in[j]),
      .sbox_data (sb_out[j])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      st    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      st    <= st_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    st_nxt    = st;
    cnt_nxt   = cnt;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;

    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          st_nxt    = sub_bytes_in;
          cnt_nxt   = '0;
          state_nxt = SUB;
        end
      end

      SUB: begin
        busy = 1'b1;
        for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
          st_nxt[{bidx[j], 3'b000} +: 8] = sb_out[j];
        end
        if (cnt == CNT_LAST) begin
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // The state register feeds the output directly, so it stays frozen while DONE waits.
  assign sub_bytes_out = st;

endmodule

// File: tb/tb_sub_bytes_serial.sv
// tb/tb_sub_bytes_serial.sv - scoreboard bench for sub_bytes_serial at BPC 1, 2, 4, 16

module tb_sub_bytes_serial;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [0:127] din = '0;
  int           sel = 0;

  logic [3:0]   in_ready_v;
  logic [3:0]   out_valid_v;
  logic [3:0]   busy_v;
  logic [0:127] dout_v [4];

  int           vectors = 0;
  int           miscompares = 0;
  int           cyc = 0;
  int           acc_cyc = 0;
  logic         ov_prev = 1'b0;
  logic [127:0] exp_q [$];

  localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int BPC_G = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : 16;
    sub_bytes_serial #(.BYTES_PER_CYCLE(BPC_G)) dut (
      .clk           (clk),
      .reset         (reset),
      .in_valid      (in_valid && (sel == g)),
      .in_ready      (in_ready_v[g]),
      .sub_bytes_in  (din),
      .out_valid     (out_valid_v[g]),
      .out_ready     (out_ready),
      .sub_bytes_out (dout_v[g]),
      .busy          (busy_v[g])
    );
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int n_of(input int s);
    case (s)
      0:       return 16;
      1:       return 8;
      2:       return 4;
      default: return 1;
    endcase
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: latency from accept to out_valid, and scoreboard pop on each output handshake.
  always @(negedge clk) begin
    if (reset) begin
      ov_prev <= 1'b0;
    end else begin
      if (in_valid && in_ready_v[sel]) acc_cyc <= cyc + 1;
      if (out_valid_v[sel] && !ov_prev) check("latency", 128'(cyc - acc_cyc), 128'(n_of(sel)));
      if (out_valid_v[sel] && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_out", 128'(exp_q.size()), 128'd1);
        else check("result", dout_v[sel], exp_q.pop_front());
      end
      ov_prev <= out_valid_v[sel];
    end
  end

  task automatic send(input logic [0:127] data, input logic [127:0] exp, input bit push);
    bit accepted;
    accepted = 1'b0;
    @(posedge clk); #1;
    din = data;
    in_valid = 1'b1;
    if (push) exp_q.push_back(exp);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready_v[sel]) begin
        accepted = 1'b1;
        break;
      end
    end
    check("accept", 128'(accepted), 128'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0) break;
    end
    check("drain", 128'(exp_q.size()), 128'd0);
  endtask

  initial begin
    // Reset asserted between edges must take effect immediately.
    #2 reset = 1'b1;
    #1;
    for (int g = 0; g < 4; g++) begin
      check("rst_in_ready", 128'(in_ready_v[g]), 128'd1);
      check("rst_out_valid", 128'(out_valid_v[g]), 128'd0);
      check("rst_busy", 128'(busy_v[g]), 128'd0);
      check("rst_dout", dout_v[g], 128'd0);
    end
    @(posedge clk); #1;
    reset = 1'b0;

    // FIPS-197 round 1 at one byte per cycle.
    sel = 0;
    out_ready = 1'b1;
    send(FIPS_IN, FIPS_OUT, 1'b1);
    drain();

    // Parameter sweep.
    for (int s = 1; s < 4; s++) begin
      sel = s;
      send('0, {16{8'h63}}, 1'b1);
      send({16{8'hFF}}, {16{8'h16}}, 1'b1);
      drain();
    end

    // Backpressure with a pending input.
    sel = 0;
    out_ready = 1'b0;
    send(FIPS_IN, FIPS_OUT, 1'b1);
    din = {16{8'h53}};
    in_valid = 1'b1;
    exp_q.push_back({16{8'hED}});
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid_v[0]) break;
    end
    for (int k = 0; k < 5; k++) begin
      check("bp_dout", dout_v[0], FIPS_OUT);
      check("bp_in_ready", 128'(in_ready_v[0]), 128'd0);
      check("bp_out_valid", 128'(out_valid_v[0]), 128'd1);
      check("bp_busy", 128'(busy_v[0]), 128'd1);
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("bp_reaccept", 128'(in_ready_v[0]), 128'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_busy_after", 128'(busy_v[0]), 128'd1);
    out_ready = 1'b1;
    drain();

    // Reset in the middle of substitution.
    send({16{8'hAA}}, '0, 1'b0);
    repeat (6) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_out_valid", 128'(out_valid_v[0]), 128'd0);
    check("mid_rst_in_ready", 128'(in_ready_v[0]), 128'd1);
    check("mid_rst_busy", 128'(busy_v[0]), 128'd0);
    check("mid_rst_dout", dout_v[0], 128'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    send({16{8'h01}}, {16{8'h7C}}, 1'b1);
    drain();

    // Input noise while busy must not disturb the accepted state.
    send(FIPS_IN, FIPS_OUT, 1'b1);
    for (int k = 0; k < 13; k++) begin
      @(posedge clk); #1;
      in_valid = 1'($urandom_range(0, 1));
      din = {$urandom(), $urandom(), $urandom(), $urandom()};
    end
    in_valid = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/sub_bytes_serial.md
# sub_bytes_serial

Iterative AES SubBytes stage that sits directly upstream of `shift_rows` in the round datapath. It accepts a 128-bit state over a valid/ready handshake and substitutes `BYTES_PER_CYCLE` bytes per clock through that many instances of the existing `sbox(address, sbox_data)` lookup. It presents the substituted state, held stable, until the downstream consumer accepts it. This trades latency for S-box area; its output wires straight into `shift_rows_in`.

## Interface
- `BYTES_PER_CYCLE`, default 1: S-box instances, and bytes substituted per cycle. Legal values are 1, 2, 4, 8 and 16.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `reset` input, 1 bit: asynchronous, active-high.
- `in_valid` input, 1 bit: `sub_bytes_in` holds a state to process.
- `in_ready` output, 1 bit: block can accept a state. High only in IDLE.
- `sub_bytes_in` input, `[0:127]`: input state. Byte i is bits `[8*i +: 8]`, so byte 0 is bits 0..7, in column-major AES order.
- `out_valid` output, 1 bit: `sub_bytes_out` holds the complete substituted state.
- `out_ready` input, 1 bit: consumer accepts the output.
- `sub_bytes_out` output, `[0:127]`: substituted state, same byte ordering as the input. Guaranteed correct only while `out_valid`=1.
- `busy` output, 1 bit: high in SUB or DONE.

## Operation
- Internal registers:
  - One 128-bit state register `st`, driving `sub_bytes_out` directly.
  - Byte-group counter `cnt`, width `clog2(16/BYTES_PER_CYCLE)`, at least 1 bit.
  - FSM state.
- The S-box instances read and write `st` in place. Instance j addresses byte `cnt*BYTES_PER_CYCLE + j`.
- FSM states:
  - **IDLE:** `in_ready`=1.
    - On `in_valid && in_ready`: load `st <= sub_bytes_in`, set `cnt <= 0`, go to SUB.
  - **SUB:** each cycle, replace bytes `cnt*BPC .. cnt*BPC+BPC-1` of `st` with their S-box outputs; all other bytes hold.
    - If `cnt == 16/BPC-1`: go to DONE.
    - Otherwise: `cnt <= cnt+1`.
    - `in_valid` is ignored in SUB.
  - **DONE:** `out_valid`=1 and `st` is frozen.
    - On `out_ready`: go to IDLE.
    - Without `out_ready`: hold indefinitely, with output stable.
- `in_ready` is low in SUB and DONE. An input offered then is not consumed and must be held by the producer.
- With `BYTES_PER_CYCLE`=16, SUB lasts exactly one cycle and `cnt` stays 0.
- Reset in any state, including mid-SUB:
  - Immediately forces IDLE and clears `st` and `cnt` to 0.
  - The partially substituted state is discarded; no output is produced for it.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `busy`=0, `sub_bytes_out`=128'h0.
- Accept edge is E0. SUB occupies the cycles after edges E0 .. E(N-1), where N = 16/BYTES_PER_CYCLE.
- `out_valid` rises after edge EN. Latency from accept to `out_valid` is N cycles: 16 with the default.
- The output handshake edge returns the FSM to IDLE. `in_ready` is high the following cycle, so the earliest next accept is one cycle after the output handshake.
  - Throughput is one state per N+2 cycles when both sides are always ready.
- If `out_ready` is already high when `out_valid` rises, the output handshake completes on the first DONE edge.
- All outputs are registered or decoded from FSM state only. There is no combinational path from any input to any output.

## Test plan
- **Reset and idle:** assert `reset` mid-cycle with no clock edge.
  - Required: `in_ready`=1, `out_valid`=0, `busy`=0 and `sub_bytes_out`=0 immediately.
- **FIPS-197 Appendix B round 1, BPC=1:** input `193de3bea0f4e22b9ac68d2ae9f84808`, `out_ready`=1.
  - Required: `out_valid` exactly 16 cycles after accept, with output `d42711aee0bf98f1b8b45de51e415230`.
  - Feeding that output through `shift_rows` gives `d4bf5d30e0b452aeb84111f11e2798e5`.
- **Parameter sweep:** BPC = 2, 4, 16 with input 128'h0.
  - Required: output `636363…63` (all 16 bytes 0x63) after 8, 4 and 1 cycles respectively.
  - Also with input all 0xFF: output all 0x16.
- **Backpressure:** hold `out_ready`=0 for 5 cycles after `out_valid` rises, while driving a new `in_valid` with all-0x53 input.
  - Required: output stable and `in_ready`=0 throughout.
  - Then raise `out_ready` for 1 cycle. One cycle later the new state is accepted, and its result is all 0xED.
- **Reset mid-operation:** assert `reset` after 7 SUB cycles, then release it and send all-0x01.
  - Required: no `out_valid` for the aborted state; the new result is all 0x7C after 16 cycles.
- **Ignored input while busy:** toggle `in_valid` and change `sub_bytes_in` randomly during SUB.
  - Required: the result matches the originally accepted state only.
